ranc_input_packet_buffer: RTL

//   Frame-aware input packet FIFO feeding the RANC network grid's input port (the read side of the

---
 rtl/ranc_input_packet_buffer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ranc_input_packet_buffer.sv
// Frame-aware input packet FIFO for the RANC grid: releases one committed frame per tick.
// Optional frames_served/packets_served counters are enabled by defining RANC_INBUF_FRAME_STATS_EN.
module ranc_input_packet_buffer #(
   parameter int PACKET_WIDTH = 30,
   parameter int ADDR_WIDTH   = 12,
   parameter int FRAME_AW     = 4,
   parameter int COUNT_WIDTH  = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [PACKET_WIDTH-1:0] wr_data,
   input  logic                    frame_close,
   output logic                    wr_full,
   output logic                    frame_fifo_full,
   input  logic                    ren_to_input_buffer,
   output logic                    input_buffer_empty,
   output logic [PACKET_WIDTH-1:0] packet_in,
   input  logic                    cores_done,
   output logic                    overflow_error,
   output logic                    underflow_error,
   output logic                    sequence_error
`ifdef RANC_INBUF_FRAME_STATS_EN
   ,
   output logic [15:0]             frames_served,
   output logic [31:0]             packets_served
`endif
);

   localparam logic [ADDR_WIDTH:0]    PTR_ONE  = 1;
   localparam logic [FRAME_AW:0]      FPTR_ONE = 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = 1;

   typedef enum logic [1:0] {
      S_WAIT,
      S_FEED,
      S_DRAINED
   } state_t;

   state_t state, state_next;

   logic [PACKET_WIDTH-1:0] pkt_mem   [2**ADDR_WIDTH];
   logic [COUNT_WIDTH-1:0]  frame_mem [2**FRAME_AW];

   logic [ADDR_WIDTH:0]    wr_ptr, rd_ptr;
   logic [FRAME_AW:0]      fwr_ptr, frd_ptr;
   logic [COUNT_WIDTH-1:0] open_count, closed_count, remaining, head_count;
   logic                   frame_empty, pkt_push, frame_push, frame_pop, rd_accept;

   assign wr_full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign frame_fifo_full = (fwr_ptr[FRAME_AW] != frd_ptr[FRAME_AW]) &&
                            (fwr_ptr[FRAME_AW-1:0] == frd_ptr[FRAME_AW-1:0]);
   assign frame_empty = (fwr_ptr == frd_ptr);

   assign pkt_push   = wr_en && !wr_full;
   assign frame_push = frame_close && !frame_fifo_full;
   // A packet pushed in the closing cycle belongs to the frame being closed.
   assign closed_count = pkt_push ? open_count + CNT_ONE : open_count;
   assign head_count   = frame_mem[frd_ptr[FRAME_AW-1:0]];

   assign input_buffer_empty = (state != S_FEED);

   always_ff @(posedge clk) begin
      if (pkt_push)
         pkt_mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
      if (frame_push)
         frame_mem[fwr_ptr[FRAME_AW-1:0]] <= closed_count;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         fwr_ptr    <= '0;
         open_count <= '0;
      end else begin
         if (pkt_push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (frame_push)
            fwr_ptr <= fwr_ptr + FPTR_ONE;
         // A dropped close keeps the open count so the packets stay in the next frame.
         open_count <= frame_push ? '0 : closed_count;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_WAIT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      frame_pop  = 1'b0;
      rd_accept  = 1'b0;
      case (state)
         S_WAIT: begin
            if (!frame_empty) begin
               frame_pop  = 1'b1;
               state_next = (head_count != '0) ? S_FEED : S_DRAINED;
            end
         end
         S_FEED: begin
            if (ren_to_input_buffer) begin
               rd_accept = 1'b1;
               if (remaining == CNT_ONE)
                  state_next = S_DRAINED;
            end
         end
         S_DRAINED: begin
            if (cores_done)
               state_next = S_WAIT;
         end
         default: state_next = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= '0;
         frd_ptr   <= '0;
         remaining <= '0;
         packet_in <= '0;
      end else begin
         if (frame_pop) begin
            frd_ptr   <= frd_ptr + FPTR_ONE;
            remaining <= head_count;
         end
         if (rd_accept) begin
            packet_in <= pkt_mem[rd_ptr[ADDR_WIDTH-1:0]];
            rd_ptr    <= rd_ptr + PTR_ONE;
            remaining <= remaining - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_error  <= 1'b0;
         underflow_error <= 1'b0;
         sequence_error  <= 1'b0;
      end else begin
         if ((wr_en && wr_full) || (frame_close && frame_fifo_full))
            overflow_error <= 1'b1;
         if (ren_to_input_buffer && state != S_FEED)
            underflow_error <= 1'b1;
         if (cores_done && state != S_DRAINED)
            sequence_error <= 1'b1;
      end
   end

`ifdef RANC_INBUF_FRAME_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frames_served  <= '0;
         packets_served <= '0;
      end else begin
         if (state == S_DRAINED && cores_done)
            frames_served <= frames_served + 16'd1;
         if (rd_accept)
            packets_served <= packets_served + 32'd1;
      end
   end
`endif

endmodule
